// File: rtl/mmu_tile_sequencer_if.sv
// Command/array-control bundle between the accelerator decoder and the tile sequencer.
// The master drives tile commands and flow control; the slave (sequencer) drives array control.
interface mmu_tile_sequencer_if #(
  parameter int K_WIDTH = 16
);
  logic               start;
  logic [K_WIDTH-1:0] k;
  logic               stall;
  logic               abort;
  logic               result_ready;

  logic               mmu_en;
  logic               mmu_sync_rst;
  logic               feed_valid;
  logic [K_WIDTH-1:0] feed_index;
  logic               busy;
  logic               result_valid;
  logic               done;

  modport master (
    output start, k, stall, abort, result_ready,
    input  mmu_en, mmu_sync_rst, feed_valid, feed_index, busy, result_valid, done
  );

  modport slave (
    input  start, k, stall, abort, result_ready,
    output mmu_en, mmu_sync_rst, feed_valid, feed_index, busy, result_valid, done
  );
endinterface

// File: rtl/mmu_tile_sequencer.sv
// Tile sequencer for the LENGTH x LENGTH systolic array: clear, feed K beats,
// drain until the far-corner PE has its last product, then hold the result.
module mmu_tile_sequencer #(
  parameter int LENGTH  = 256,
  parameter int K_WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  mmu_tile_sequencer_if.slave bus
);

  localparam int DRAIN_CYCLES = 2 * LENGTH - 1;
  localparam int DW           = $clog2(2 * LENGTH);

  localparam logic [K_WIDTH-1:0] K_ONE      = K_WIDTH'(1);
  localparam logic [DW-1:0]      DRAIN_ONE  = DW'(1);
  localparam logic [DW-1:0]      DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [K_WIDTH-1:0] beat_q, beat_d;
  logic [DW-1:0]      drain_q, drain_d;

  logic mmu_en;
  logic mmu_sync_rst;
  logic feed_valid;
  logic result_valid;
  logic done;

  // Outputs are decoded from registered state plus same-cycle STALL/ABORT/RESULT_READY.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    beat_d       = beat_q;
    drain_d      = drain_q;
    mmu_en       = 1'b0;
    mmu_sync_rst = 1'b0;
    feed_valid   = 1'b0;
    result_valid = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          k_d     = bus.k;
          beat_d  = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        mmu_sync_rst = 1'b1;
        state_d      = (k_q != '0) ? FEED : HOLD;
      end
      FEED: begin
        feed_valid = 1'b1;
        mmu_en     = !bus.stall;
        if (mmu_en) begin
          if (beat_q == k_q - K_ONE) begin
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            beat_d = beat_q + K_ONE;
          end
        end
      end
      DRAIN: begin
        mmu_en = !bus.stall;
        if (mmu_en) begin
          if (drain_q == DRAIN_LAST) begin
            state_d = HOLD;
          end else begin
            drain_d = drain_q + DRAIN_ONE;
          end
        end
      end
      HOLD: begin
        result_valid = 1'b1;
        if (bus.result_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wipes the accumulators and suppresses any handshake; the index just holds.
    if (bus.abort && state_q != IDLE) begin
      mmu_en       = 1'b0;
      mmu_sync_rst = 1'b1;
      feed_valid   = 1'b0;
      result_valid = 1'b0;
      done         = 1'b0;
      beat_d       = beat_q;
      drain_d      = drain_q;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  assign bus.mmu_en       = mmu_en;
  assign bus.mmu_sync_rst = mmu_sync_rst;
  assign bus.feed_valid   = feed_valid;
  assign bus.feed_index   = beat_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = result_valid;
  assign bus.done         = done;

endmodule

// File: tb/tb_mmu_tile_sequencer.sv
// Bench for mmu_tile_sequencer: directed scenarios plus random traffic, all checked
// cycle by cycle against a tile-progress model (work cycles done vs. work required).
module tb_mmu_tile_sequencer;
  localparam int LEN = 4;
  localparam int KW  = 8;
  localparam int D   = 2 * LEN - 1;
  localparam int VW  = KW + 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmu_tile_sequencer_if #(.K_WIDTH(KW)) bus ();

  mmu_tile_sequencer #(.LENGTH(LEN), .K_WIDTH(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc;

  // Tile model: a tile is one clear cycle, then K+D enabled work cycles (0 if K=0), then hold.
  bit m_in_tile;
  int m_pos;
  int m_work;
  int m_k;
  int m_last_idx;

  logic [VW-1:0] exp_v, obs_v;

  task automatic model_reset();
    m_in_tile  = 1'b0;
    m_pos      = 0;
    m_work     = 0;
    m_k        = 0;
    m_last_idx = 0;
  endtask

  task automatic predict();
    bit en, srst, fv, rv, dn;
    int idx, total;
    en = 0; srst = 0; fv = 0; rv = 0; dn = 0;
    idx = m_last_idx;
    total = (m_k == 0) ? 0 : m_k + D;
    if (m_in_tile) begin
      if (m_pos == 0) begin
        srst = 1; idx = 0;
      end else if (m_work < total) begin
        en  = !bus.stall;
        fv  = (m_work < m_k);
        idx = fv ? m_work : m_k - 1;
      end else begin
        rv  = 1;
        dn  = bus.result_ready;
        idx = (m_k == 0) ? 0 : m_k - 1;
      end
      if (bus.abort) begin
        en = 0; srst = 1; fv = 0; rv = 0; dn = 0;
      end
    end
    m_last_idx = idx;
    exp_v = {en, srst, fv, rv, dn, m_in_tile, KW'(idx)};
  endtask

  task automatic drive(input bit s, input int k, input bit st, input bit ab, input bit rd);
    bus.start        = s;
    bus.k            = KW'(k);
    bus.stall        = st;
    bus.abort        = ab;
    bus.result_ready = rd;
    #2;
    predict();
    obs_v = {bus.mmu_en, bus.mmu_sync_rst, bus.feed_valid, bus.result_valid,
             bus.done, bus.busy, bus.feed_index};
  endtask

  task automatic advance();
    int total;
    total = (m_k == 0) ? 0 : m_k + D;
    @(posedge clk);
    if (m_in_tile) begin
      if (bus.abort)             m_in_tile = 1'b0;
      else if (m_pos == 0)       m_pos = 1;
      else if (m_work < total)   m_work += bus.stall ? 0 : 1;
      else if (bus.result_ready) m_in_tile = 1'b0;
    end else if (bus.start) begin
      m_in_tile = 1'b1;
      m_pos     = 0;
      m_work    = 0;
      m_k       = int'(bus.k);
    end
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 0; bus.k = '0; bus.stall = 0; bus.abort = 0; bus.result_ready = 0;
    model_reset();
    #1;
    obs_v = {bus.mmu_en, bus.mmu_sync_rst, bus.feed_valid, bus.result_valid,
             bus.done, bus.busy, bus.feed_index};
    checks++;
    if (obs_v !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs got=%h exp=0", obs_v);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_basic();
    int done_cyc = -1;
    cyc = 0;
    for (int i = 0; i < 14; i++) begin
      drive(cyc == 0, 3, 0, 0, 1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("[TB] FAIL basic cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (bus.done && done_cyc < 0) done_cyc = cyc;
      advance();
    end
    checks++;
    if (done_cyc !== 12) begin
      errors++; $display("[TB] FAIL basic_done_cycle got=%0d exp=12", done_cyc);
    end
  endtask

  task automatic test_stall();
    int done_cyc = -1;
    cyc = 0;
    for (int i = 0; i < 16; i++) begin
      drive(cyc == 0, 3, (cyc == 3) || (cyc == 8), 0, 1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("[TB] FAIL stall cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (bus.done && done_cyc < 0) done_cyc = cyc;
      advance();
    end
    checks++;
    if (done_cyc !== 14) begin
      errors++; $display("[TB] FAIL stall_done_cycle got=%0d exp=14", done_cyc);
    end
  endtask

  task automatic test_backpressure();
    int done_cyc = -1;
    bit busy21 = 1'b1;
    cyc = 0;
    for (int i = 0; i < 23; i++) begin
      drive((cyc == 0) || (cyc == 15), (cyc == 15) ? 5 : 3, 0, 0, cyc >= 20);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("[TB] FAIL backpressure cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (bus.done && done_cyc < 0) done_cyc = cyc;
      if (cyc == 21) busy21 = bus.busy;
      advance();
    end
    checks++;
    if (done_cyc !== 20 || busy21 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_handshake done_cyc=%0d busy21=%0b exp done_cyc=20 busy21=0",
               done_cyc, busy21);
    end
  endtask

  task automatic test_k_zero();
    int rv_cyc = -1;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(cyc == 0, 0, 0, 0, cyc >= 3);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("[TB] FAIL k_zero cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (bus.result_valid && rv_cyc < 0) rv_cyc = cyc;
      advance();
    end
    checks++;
    if (rv_cyc !== 2) begin
      errors++; $display("[TB] FAIL k_zero_valid_cycle got=%0d exp=2", rv_cyc);
    end
  endtask

  task automatic test_abort();
    int done_cnt = 0;
    int done_cyc = -1;
    cyc = 0;
    for (int i = 0; i < 22; i++) begin
      drive((cyc == 0) || (cyc == 8), 3, 0, cyc == 6, 1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("[TB] FAIL abort cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      advance();
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 20) begin
      errors++;
      $display("[TB] FAIL abort_done got count=%0d cyc=%0d exp count=1 cyc=20", done_cnt, done_cyc);
    end
  endtask

  task automatic test_async_reset();
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      drive(cyc == 0, 3, 0, 0, 1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("[TB] FAIL async_pre cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      advance();
    end
    drive(0, 3, 0, 0, 1);
    #1 rst = 1'b1;
    #1;
    obs_v = {bus.mmu_en, bus.mmu_sync_rst, bus.feed_valid, bus.result_valid,
             bus.done, bus.busy, bus.feed_index};
    checks++;
    if (obs_v !== '0) begin
      errors++; $display("[TB] FAIL async_reset_outputs got=%h exp=0", obs_v);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("[TB] FAIL async_post got=%h exp=%h", obs_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_random();
    cyc = 0;
    for (int i = 0; i < 800; i++) begin
      drive(($urandom % 4) == 0, $urandom_range(0, 5), ($urandom % 4) == 0,
            ($urandom % 40) == 0, ($urandom % 3) == 0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_k_zero();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
